// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit and its memory port: access sizes,
// controller states and the per-beat drive helper.
package definitions;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_access_size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    typedef struct packed {
        logic [31:0]      addr;
        mem_access_size_t size;
        logic [31:0]      data;
    } lsu_beat_t;

    function automatic logic is_misaligned(input mem_access_size_t size, input logic [31:0] addr);
        return (size == SIZE_HALF && addr[0]) || (size == SIZE_WORD && addr[1:0] != 2'b00);
    endfunction

    function automatic logic [1:0] last_beat_idx(input mem_access_size_t size, input logic split);
        if (!split)
            return 2'd0;
        return (size == SIZE_WORD) ? 2'd3 : 2'd1;
    endfunction

    // Split beats walk the address one byte at a time and carry byte lane k in bits [7:0].
    function automatic lsu_beat_t beat_drive(input mem_access_size_t size, input logic [31:0] addr,
                                             input logic [31:0] data, input logic split,
                                             input logic [1:0] k);
        lsu_beat_t b;
        if (split) begin
            b.addr = addr + {30'd0, k};
            b.size = SIZE_BYTE;
            b.data = {24'd0, data[{k, 3'b000} +: 8]};
        end else begin
            b.addr = addr;
            b.size = size;
            b.data = data;
        end
        return b;
    endfunction

endpackage

// File: rtl/mem_if.sv
// Simple memory port: registered request side driven by the LSU, read data
// returned combinationally by the memory.
interface mem_if;
    import definitions::*;

    logic [31:0]      rd_addr;
    mem_access_size_t rd_size;
    logic [31:0]      rd_data;
    logic             wr_enable;
    logic [31:0]      wr_addr;
    logic [31:0]      wr_data;
    mem_access_size_t wr_size;

    modport slave (
        output rd_addr, rd_size, wr_enable, wr_addr, wr_data, wr_size,
        input  rd_data
    );

    modport master (
        input  rd_addr, rd_size, wr_enable, wr_addr, wr_data, wr_size,
        output rd_data
    );
endinterface

// File: rtl/load_extend.sv
// Zero/sign extension of raw load data to 32 bits according to access size.
module load_extend
    import definitions::*;
(
    input  logic [31:0]      data_i,
    input  mem_access_size_t size_i,
    input  logic             signed_i,
    output logic [31:0]      result_o
);

    always_comb begin
        result_o = data_i;
        case (size_i)
            SIZE_BYTE: result_o = {{24{signed_i & data_i[7]}}, data_i[7:0]};
            SIZE_HALF: result_o = {{16{signed_i & data_i[15]}}, data_i[15:0]};
            default:   result_o = data_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: accepts one request, runs one or more
// memory beats (misaligned accesses optionally split into bytes), then responds.
module load_store_unit
    import definitions::*;
#(
    parameter int SPLIT_MISALIGNED = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_we_i,
    input  mem_access_size_t req_size_i,
    input  logic             req_signed_i,
    input  logic [31:0]      req_addr_i,
    input  logic [31:0]      req_wdata_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_rdata_o,
    mem_if.slave             memif
);

    lsu_state_t       state_q, state_d;
    logic [1:0]       beat_q, beat_d;
    logic             we_q, signed_q;
    mem_access_size_t size_q;
    logic [31:0]      addr_q, wdata_q;
    logic [31:0]      asm_q, asm_d;
    logic             rsp_valid_q;
    logic [31:0]      rsp_rdata_q;
    logic [31:0]      rd_addr_q, wr_addr_q, wr_data_q;
    mem_access_size_t rd_size_q, wr_size_q;

    logic             req_split, split, last_beat;
    lsu_beat_t        beat0, beat_nxt;
    logic [31:0]      ext_result;

    assign req_split = (SPLIT_MISALIGNED != 0) && is_misaligned(req_size_i, req_addr_i);
    assign split     = (SPLIT_MISALIGNED != 0) && is_misaligned(size_q, addr_q);
    assign last_beat = (beat_q == last_beat_idx(size_q, split));
    assign beat0     = beat_drive(req_size_i, req_addr_i, req_wdata_i, req_split, 2'd0);
    assign beat_nxt  = beat_drive(size_q, addr_q, wdata_q, split, beat_q + 2'd1);

    // Split loads collect one byte per beat; the last beat's byte is merged
    // combinationally so the response can be registered on that same edge.
    always_comb begin
        asm_d = asm_q;
        if (split)
            asm_d[{beat_q, 3'b000} +: 8] = memif.rd_data[7:0];
        else
            asm_d = memif.rd_data;
    end

    load_extend u_load_extend (
        .data_i   (asm_d),
        .size_i   (size_q),
        .signed_i (signed_q),
        .result_o (ext_result)
    );

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        req_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_d = ACCESS;
                    beat_d  = 2'd0;
                end
            end
            ACCESS: begin
                if (last_beat)
                    state_d = RESP;
                else
                    beat_d = beat_q + 2'd1;
            end
            RESP: begin
                if (rsp_ready_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            beat_q      <= 2'd0;
            we_q        <= 1'b0;
            signed_q    <= 1'b0;
            size_q      <= SIZE_BYTE;
            addr_q      <= '0;
            wdata_q     <= '0;
            asm_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rd_addr_q   <= '0;
            rd_size_q   <= SIZE_BYTE;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_size_q   <= SIZE_BYTE;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        we_q      <= req_we_i;
                        size_q    <= req_size_i;
                        signed_q  <= req_signed_i;
                        addr_q    <= req_addr_i;
                        wdata_q   <= req_wdata_i;
                        asm_q     <= '0;
                        rd_addr_q <= beat0.addr;
                        rd_size_q <= beat0.size;
                        wr_addr_q <= beat0.addr;
                        wr_data_q <= beat0.data;
                        wr_size_q <= beat0.size;
                    end
                end
                ACCESS: begin
                    asm_q <= asm_d;
                    if (last_beat) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= we_q ? 32'd0 : ext_result;
                        rd_size_q   <= SIZE_BYTE;
                    end else begin
                        rd_addr_q <= beat_nxt.addr;
                        rd_size_q <= beat_nxt.size;
                        wr_addr_q <= beat_nxt.addr;
                        wr_data_q <= beat_nxt.data;
                        wr_size_q <= beat_nxt.size;
                    end
                end
                RESP: begin
                    if (rsp_ready_i)
                        rsp_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Write strobe is gated by reset directly so an aborted beat never lands.
    assign memif.wr_enable = rst_ni && (state_q == ACCESS) && we_q;
    assign memif.rd_addr   = rd_addr_q;
    assign memif.rd_size   = rd_size_q;
    assign memif.wr_addr   = wr_addr_q;
    assign memif.wr_data   = wr_data_q;
    assign memif.wr_size   = wr_size_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_rdata_o     = rsp_rdata_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter SPLIT_MISALIGNED, default 1: 1 splits misaligned accesses into byte beats; 0 issues them as one access.
REQ-002 SHALL have port clk_i, input, 1: the single clock.
REQ-003 SHALL have port rst_ni, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port req_valid_i, input, 1: request present.
REQ-005 SHALL have port req_ready_o, output, 1: request accepted when high with req_valid_i.
REQ-006 SHALL have port req_we_i, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port req_size_i, input, mem_access_size_t: BYTE, HALF or WORD.
REQ-008 SHALL have port req_signed_i, input, 1: sign-extend load data.
REQ-009 SHALL have port req_addr_i, input, 32: byte address.
REQ-010 SHALL have port req_wdata_i, input, 32: store data, LSB-aligned.
REQ-011 SHALL have port rsp_valid_o, output, 1: response present.
REQ-012 SHALL have port rsp_ready_i, input, 1: response consumed.
REQ-013 SHALL have port rsp_rdata_o, output, 32: extended load data; 0 for stores.
REQ-014 SHALL have port memif, mem_if.slave, as the initiating end. It drives rd_addr, rd_size, wr_enable, wr_addr, wr_data and wr_size, and samples rd_data combinationally.

Function
REQ-015 SHALL use an FSM with states IDLE, ACCESS and RESP.
REQ-016 IDLE SHALL hold req_ready_o=1; all other states SHALL hold it at 0.
REQ-017 On req_valid_i && req_ready_o, the unit SHALL register we, size, signed, addr and wdata, clear the beat counter, and enter ACCESS.
REQ-018 An access is misaligned when it is HALF with addr[0]=1, or WORD with addr[1:0]!=0.
REQ-019 Beat count SHALL be 1 for aligned accesses or when SPLIT_MISALIGNED=0, and 2 (HALF) or 4 (WORD) for split accesses.
REQ-020 Each beat SHALL last one cycle. Beat k of a split access SHALL use size BYTE, address addr+k and byte lane k of wdata; a non-split beat SHALL use the registered size and addr.
REQ-021 In ACCESS for a store, wr_enable SHALL be 1 for every beat; it SHALL be 0 in every other state and whenever rst_ni=0.
REQ-022 In ACCESS for a load, rd_data SHALL be sampled at each beat's clock edge. Split beats SHALL deposit rd_data[7:0] into byte k of an assembly register.
REQ-023 After the last beat the unit SHALL enter RESP with rsp_valid_o=1 and rsp_rdata_o stable.
REQ-024 Load data SHALL be zero-extended, or sign-extended when signed=1, from bit 7 (BYTE) or bit 15 (HALF). WORD data SHALL pass unchanged.
REQ-025 RESP SHALL hold until rsp_ready_i=1, then go to IDLE. A new request SHALL NOT be accepted in that same cycle.
REQ-026 Latency from the accept edge to rsp_valid_o SHALL be beats+1 cycles: 2 aligned, 3 split HALF, 5 split WORD.
REQ-027 The 2-bit beat counter SHALL wrap only via clear-on-accept and SHALL never exceed beats-1.
REQ-028 Address arithmetic addr+k SHALL be 32-bit modulo; 0xFFFFFFFF+1 wraps to 0x00000000.
REQ-029 Outside ACCESS, memif addresses and data SHALL hold their last values and rd_size SHALL hold BYTE.

Reset
REQ-030 At the clock edge with rst_ni=0, the unit SHALL set: state IDLE, rsp_valid_o=0, rsp_rdata_o=0, beat counter 0, and all registered request fields 0.
REQ-031 At that edge, memif rd_addr, wr_addr and wr_data SHALL become 0, and rd_size and wr_size SHALL become BYTE.
REQ-032 Reset during ACCESS SHALL abort the access; no write SHALL occur in any cycle where rst_ni=0.
REQ-033 Reset during RESP SHALL drop the pending response without a handshake.

Structure
REQ-034 lsu_state_t SHALL be added to package definitions. mem_access_size_t SHALL be reused from definitions.
REQ-035 Load extension SHALL be a combinational sub-module named load_extend, with inputs data[31:0], size and signed, and output result[31:0].

Verification
REQ-036 Aligned WORD load at 0x1000, memory bytes 0x11,0x22,0x33,0x44 -> rsp_rdata_o=0x44332211, rsp_valid_o 2 cycles after accept.
REQ-037 Signed BYTE load at 0x1003 holding 0x80 -> 0xFFFFFF80; the same access unsigned -> 0x00000080.
REQ-038 Misaligned WORD store 0xAABBCCDD to 0x1001 with SPLIT_MISALIGNED=1 -> 4 byte writes to 0x1001..0x1004 of DD,CC,BB,AA; then a WORD load at 0x1001 returns 0xAABBCCDD after 5 cycles.
REQ-039 rsp_ready_i held 0 for 3 cycles -> rsp_valid_o and rsp_rdata_o stay stable and req_ready_o stays 0; the request accepted after RESP completes is served normally.
REQ-040 rst_ni=0 during beat 2 of a split WORD store -> wr_enable=0 in that cycle, bytes 3-4 unwritten, state IDLE and rsp_valid_o=0 after the reset edge.
